seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the 8-digit common-anode seven-segment display. It holds a double-buffered copy of eight hex digits, decimal points and per-digit enables, and steps one anode at a time through the digits. A blanking gap between digits suppresses ghosting. Each digit value is converted to active-low segment lines by a single internal decoder. The block sits between the register/UI logic and the board display pins.

---
 rtl/seven_seg_pkg.sv | 18 +
 rtl/seven_seg_hex_decode.sv | 11 +
 rtl/seven_seg_scan_ctrl.sv | 138 +++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} patterns, entry 15 first so SEG_TABLE[n] is hex digit n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex digit to active-low seven-segment decoder.
module seven_seg_hex_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner with blanking gaps,
// leading-zero suppression and frame-synchronous double-buffered update.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int DRIVE_CYCLES = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digits,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    input  logic        blank_lz,
    input  logic        upd_req,
    output logic        upd_ack,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  an,
    output logic        frame_tick
);

    localparam int MAX_CYC = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;

    logic [31:0] digits_sh;
    logic [7:0]  dp_sh;
    logic [7:0]  en_sh;
    logic        blz_sh;

    logic        blank_done, drive_done, boundary;
    logic [7:0]  lz_mask;
    logic        zero_run;
    logic [3:0]  sel_digit;
    logic [6:0]  seg_dec;
    logic        lit;
    logic [7:0]  an_nxt;
    logic [6:0]  seg_nxt;
    logic        dp_nxt;

    assign blank_done = (state == BLANK) && (cnt == BLANK_LAST);
    assign drive_done = (state == DRIVE) && (cnt == DRIVE_LAST);
    assign boundary   = blank_done && (idx == 3'd0);

    always_ff @(posedge clk) begin
        if (rst) state <= BLANK;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (blank_done)      state_nxt = DRIVE;
        else if (drive_done) state_nxt = BLANK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (blank_done || drive_done) begin
            cnt <= '0;
            if (drive_done) idx <= idx + 3'd1;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Shadow copy only changes at the frame boundary, so a frame never mixes old and new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits_sh <= '0;
            dp_sh     <= '0;
            en_sh     <= '0;
            blz_sh    <= 1'b0;
        end else if (boundary && upd_req) begin
            digits_sh <= digits;
            dp_sh     <= dp_in;
            en_sh     <= digit_en;
            blz_sh    <= blank_lz;
        end
    end

    // A digit is a leading zero when it and every digit to its left are zero; digit 0 is exempt.
    always_comb begin
        lz_mask  = '0;
        zero_run = blz_sh;
        for (int i = 7; i >= 1; i--) begin
            zero_run   = zero_run && (digits_sh[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    assign sel_digit = digits_sh[{idx, 2'b00} +: 4];

    seven_seg_hex_decode u_decode (
        .digit (sel_digit),
        .seg   (seg_dec)
    );

    assign lit = en_sh[idx] && !lz_mask[idx];

    always_comb begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_OFF;
        dp_nxt  = 1'b1;
        if (state == DRIVE) begin
            if (lit) begin
                an_nxt[idx] = 1'b0;
                seg_nxt     = seg_dec;
            end
            if (en_sh[idx]) dp_nxt = ~dp_sh[idx];
        end
    end

    // Output register stage: pins follow the state one clock later.
    always_ff @(posedge clk) begin
        if (rst) begin
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
            upd_ack    <= 1'b0;
        end else begin
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_tick <= boundary;
            upd_ack    <= boundary && upd_req;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: table vectors, hand sequences and random updates
// checked every cycle against a slot-arithmetic reference model.
module tb_seven_seg_scan_ctrl;

    localparam int DC    = 4;
    localparam int BC    = 2;
    localparam int SLOT  = DC + BC;
    localparam int FRAME = 8 * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] digits;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic        blank_lz;
    logic        upd_req;
    logic        upd_ack;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic        frame_tick;

    seven_seg_scan_ctrl #(.DRIVE_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .blank_lz   (blank_lz),
        .upd_req    (upd_req),
        .upd_ack    (upd_ack),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] hex7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    // Reference model: m_c counts clocks since reset; shadow copies captured at frame boundaries.
    int          m_c = 0;
    logic [31:0] m_dig = '0;
    logic [7:0]  m_dp = '0, m_en = '0;
    logic        m_blz = 1'b0, m_ack = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_c <= 0; m_dig <= '0; m_dp <= '0; m_en <= '0; m_blz <= 1'b0; m_ack <= 1'b0;
        end else begin
            m_c <= m_c + 1;
            if ((m_c % FRAME) == BC - 1 && upd_req) begin
                m_dig <= digits; m_dp <= dp_in; m_en <= digit_en; m_blz <= blank_lz;
                m_ack <= 1'b1;
            end else begin
                m_ack <= 1'b0;
            end
        end
    end

    function automatic void exp_disp(input int k, output logic [7:0] ea,
                                     output logic [6:0] es, output logic ed);
        int s, i;
        logic sup;
        logic [31:0] upper;
        s = k % SLOT;
        i = (k / SLOT) % 8;
        ea = 8'hFF; es = 7'h7F; ed = 1'b1;
        if (s >= BC) begin
            upper = m_dig >> (4 * i);
            sup = m_blz && (i >= 1) && (upper == 32'h0);
            if (m_en[i] && !sup) begin
                ea = ~(8'h01 << i);
                es = hex7(upper[3:0]);
            end
            if (m_en[i]) ed = ~m_dp[i];
        end
    endfunction

    always @(negedge clk) begin
        logic [7:0] ea;
        logic [6:0] es;
        logic ed, et;
        if (chk_en) begin
            if (m_c == 0) begin
                ea = 8'hFF; es = 7'h7F; ed = 1'b1; et = 1'b0;
            end else begin
                exp_disp(m_c - 1, ea, es, ed);
                et = ((m_c - 1) % FRAME) == BC - 1;
            end
            chk("an", an, ea);
            chk("seg", seg, es);
            chk("dp", dp, ed);
            chk("frame_tick", frame_tick, et);
            chk("upd_ack", upd_ack, m_ack);
            chk("one_anode", ($countones(~an) <= 1), 1);
        end
    end

    typedef struct packed {
        logic [31:0] digits;
        logic [7:0]  dp_in;
        logic [7:0]  en;
        logic        blz;
        logic [63:0] an;
        logic [55:0] seg;
        logic [7:0]  dp;
    } vec_t;

    vec_t tv [7];

    task automatic do_update(input logic [31:0] d, input logic [7:0] p,
                             input logic [7:0] e, input logic b);
        int waited;
        logic got;
        digits = d; dp_in = p; digit_en = e; blank_lz = b; upd_req = 1'b1;
        got = 1'b0; waited = 0;
        while (!got && waited < FRAME + 12) begin
            @(negedge clk);
            waited++;
            if (upd_ack) got = 1'b1;
        end
        upd_req = 1'b0;
        chk("ack_latency_ok", (got && waited <= FRAME + 1), 1);
    endtask

    task automatic wait_tick();
        int waited;
        logic got;
        got = 1'b0; waited = 0;
        while (!got && waited < FRAME + 12) begin
            @(negedge clk);
            waited++;
            if (frame_tick) got = 1'b1;
        end
        chk("tick_seen", got, 1);
    endtask

    initial begin
        int n;
        tv[0] = '{32'h76543210, 8'h00, 8'hFF, 1'b0, 64'h7FBFDFEFF7FBFDFE,
                  {7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40}, 8'hFF};
        tv[1] = '{32'h000000F8, 8'h04, 8'hFF, 1'b1, 64'hFFFFFFFFFFFFFDFE,
                  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h0E, 7'h00}, 8'hFB};
        tv[2] = '{32'h000000F8, 8'h04, 8'hFF, 1'b0, 64'h7FBFDFEFF7FBFDFE,
                  {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h0E, 7'h00}, 8'hFB};
        tv[3] = '{32'h76543210, 8'h00, 8'h05, 1'b0, 64'hFFFFFFFFFFFBFFFE,
                  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h24, 7'h7F, 7'h40}, 8'hFF};
        tv[4] = '{32'hFEDCBA98, 8'hAA, 8'hFF, 1'b1, 64'h7FBFDFEFF7FBFDFE,
                  {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00}, 8'h55};
        tv[5] = '{32'h00000000, 8'h01, 8'hFF, 1'b1, 64'hFFFFFFFFFFFFFFFE,
                  {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 8'hFE};
        tv[6] = '{32'h00102000, 8'h00, 8'hFF, 1'b1, 64'hFFFFDFEFF7FBFDFE,
                  {7'h7F, 7'h7F, 7'h79, 7'h40, 7'h24, 7'h40, 7'h40, 7'h40}, 8'hFF};

        rst = 1'b1; upd_req = 1'b0; digits = '0; dp_in = '0; digit_en = '0; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_an", an, 8'hFF);
        chk("reset_seg", seg, 7'h7F);
        chk_en = 1'b1;
        rst = 1'b0;
        repeat (200) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            do_update(tv[v].digits, tv[v].dp_in, tv[v].en, tv[v].blz);
            for (int j = 1; j < FRAME; j++) begin
                @(negedge clk);
                if (j % SLOT == BC) begin
                    chk($sformatf("vec%0d_an%0d", v, j / SLOT), an, tv[v].an[8*(j/SLOT) +: 8]);
                    chk($sformatf("vec%0d_seg%0d", v, j / SLOT), seg, tv[v].seg[7*(j/SLOT) +: 7]);
                    chk($sformatf("vec%0d_dp%0d", v, j / SLOT), dp, tv[v].dp[j/SLOT]);
                end
            end
        end

        // Request raised mid-frame with data changing while it waits.
        wait_tick();
        repeat (10) @(negedge clk);
        digits = 32'h11111111; dp_in = 8'h00; digit_en = 8'hFF; blank_lz = 1'b0; upd_req = 1'b1;
        repeat (10) @(negedge clk);
        chk("hold_old_an", an | 8'h00, an);
        digits = 32'h22222225;
        do_update(32'h22222225, 8'h00, 8'hFF, 1'b0);
        repeat (BC) @(negedge clk);
        chk("late_data_an", an, 8'hFE);
        chk("late_data_seg", seg, 7'h12);

        // Reset pulse while digit 3 is lit.
        wait_tick();
        for (int j = 1; j <= 3 * SLOT + BC; j++) @(negedge clk);
        chk("pre_rst_an", an, 8'hF7);
        chk("pre_rst_seg", seg, 7'h24);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_an", an, 8'hFF);
        chk("rst_seg", seg, 7'h7F);
        chk("rst_dp", dp, 1);
        n = 0;
        while (!frame_tick && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("rst_idx_restart", n, BC);

        for (int r = 0; r < 8; r++) begin
            repeat ($urandom_range(0, 50)) @(negedge clk);
            do_update($urandom >> (4 * $urandom_range(0, 7)), 8'($urandom),
                      8'($urandom), 1'($urandom));
            repeat ($urandom_range(20, 60)) @(negedge clk);
        end
        repeat (FRAME) @(negedge clk);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
